keypad_scan: RTL

- Scans a 4x4 matrix keypad for the door lock and emits debounced key events.
- Sits directly downstream of the clock divider. Its slow square-wave output enters as scan_clk and paces column stepping and debounce.
- Everything runs on the single system clock clk. scan_clk is used only as a synchronized enable, never as a clock.
- Feeds the password/lock FSM through a one-cycle key_valid pulse plus key_code.

---
 rtl/keypad_scan_if.sv | 13 +
 rtl/keypad_scan.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/keypad_scan_if.sv
// Keypad matrix and key-event bundle shared by the scanner and its consumer.
`timescale 1ns/1ps

interface keypad_scan_if;
  logic [3:0] row;
  logic [3:0] col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  modport master (input row, output col, output key_valid, output key_code, output key_held);
  modport slave  (output row, input col, input key_valid, input key_code, input key_held);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: steps one-hot column drive on each divided scan_clk
// rising edge, debounces press and release, and emits one key_valid pulse
// per accepted press.
`timescale 1ns/1ps

module keypad_scan #(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scan_clk,
  keypad_scan_if.master kp
);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;

  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_CNT);

  logic [2:0] scan_sync_q, scan_sync_d;
  logic [3:0] row_sync1_q, row_sync1_d;
  logic [3:0] row_sync2_q, row_sync2_d;
  logic [1:0] state_q, state_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [1:0] row_idx_q, row_idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;

  logic       step;
  logic       row_any;
  logic       row_hit;
  logic [1:0] row_sel;
  logic [3:0] cnt_inc;

  assign step    = scan_sync_q[1] & ~scan_sync_q[2];
  assign row_any = |row_sync2_q;
  assign row_hit = row_sync2_q[row_idx_q];
  assign cnt_inc = cnt_q + 4'd1;

  // Pick the lowest-numbered active row when several keys share a column.
  always_comb begin
    row_sel = 2'd0;
    if (row_sync2_q[0])      row_sel = 2'd0;
    else if (row_sync2_q[1]) row_sel = 2'd1;
    else if (row_sync2_q[2]) row_sel = 2'd2;
    else if (row_sync2_q[3]) row_sel = 2'd3;
  end

  // Synchronizer shifts plus the scan/debounce/hold sequencing, advanced only on step.
  always_comb begin
    scan_sync_d = {scan_sync_q[1:0], scan_clk};
    row_sync1_d = kp.row;
    row_sync2_d = row_sync1_q;
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;

    if (step) begin
      case (state_q)
        ST_SCAN: begin
          if (row_any) begin
            row_idx_d = row_sel;
            if (DB_LIMIT == 4'd1) begin
              key_code_d  = {col_idx_q, row_sel};
              key_valid_d = 1'b1;
              cnt_d       = 4'd0;
              state_d     = ST_HOLD;
            end else begin
              cnt_d   = 4'd1;
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (row_hit) begin
            if (cnt_inc == DB_LIMIT) begin
              key_code_d  = {col_idx_q, row_idx_q};
              key_valid_d = 1'b1;
              cnt_d       = 4'd0;
              state_d     = ST_HOLD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d     = 4'd0;
            state_d   = ST_SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_HOLD: begin
          if (!row_hit) begin
            if (cnt_inc == DB_LIMIT) begin
              cnt_d     = 4'd0;
              state_d   = ST_SCAN;
              col_idx_d = col_idx_q + 2'd1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: begin
          cnt_d   = 4'd0;
          state_d = ST_SCAN;
        end
      endcase
    end
  end

  // State and synchronizer registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_sync_q <= 3'd0;
      row_sync1_q <= 4'd0;
      row_sync2_q <= 4'd0;
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      row_idx_q   <= 2'd0;
      cnt_q       <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
    end else begin
      scan_sync_q <= scan_sync_d;
      row_sync1_q <= row_sync1_d;
      row_sync2_q <= row_sync2_d;
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign kp.col       = 4'b0001 << col_idx_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_held  = (state_q == ST_HOLD);

endmodule
